// File: rtl/serial_full_subtractor_pkg.sv
// Shared definitions for the bit-serial adder/subtractor family:
// FSM state encoding and sizing helpers.
package serial_full_subtractor_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_SHIFT = 2'd1;
    localparam logic [1:0] STATE_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_SHIFT = STATE_SHIFT,
        ST_DONE  = STATE_DONE
    } state_t;

    // Bit counter width; the +1 keeps the counter at least one bit wide
    // when the operand width is 1.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_full_subtractor_if.sv
// Producer/consumer handshake bundle for the serial subtractor.
// The block itself connects through the slave modport; whoever feeds
// operands and drains results uses the master modport.
interface serial_full_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
endinterface

// File: rtl/serial_full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
// Purely combinational; the serial top time-multiplexes a single copy.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when the minuend bit cannot cover b plus the incoming borrow.
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_full_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles.
// Operands are captured on acceptance, shifted through one full-subtractor
// cell, and the result is held in DONE until the consumer takes it.
module serial_full_subtractor
    import serial_full_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    serial_full_subtractor_if.slave    bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   d_sh_r;
    logic [WIDTH-1:0]   d_sh_next_s;
    logic               brw_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               cell_d_s;
    logic               cell_bo_s;
    logic               last_s;

    full_subtractor_cell u_cell (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .bin  (brw_r),
        .d    (cell_d_s),
        .bout (cell_bo_s)
    );

    assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

    // The new result bit enters at the MSB so that after WIDTH shifts the
    // first (LSB) bit has reached position 0. A 1-bit result has nothing
    // to shift, so it simply takes the cell output.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign d_sh_next_s = cell_d_s;
        end else begin : g_res_wn
            assign d_sh_next_s = {cell_d_s, d_sh_r[WIDTH-1:1]};
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: accept in IDLE, WIDTH shift cycles, hold until drained.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, shift one bit per SHIFT cycle,
    // hold everything otherwise so diff/bout stay stable in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            d_sh_r <= {WIDTH{1'b0}};
            brw_r  <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh_r <= bus.a;
                        b_sh_r <= bus.b;
                        brw_r  <= bus.bin;
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    a_sh_r <= a_sh_r >> 1'b1;
                    b_sh_r <= b_sh_r >> 1'b1;
                    d_sh_r <= d_sh_next_s;
                    brw_r  <= cell_bo_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                end
                default: begin
                    a_sh_r <= a_sh_r;
                    b_sh_r <= b_sh_r;
                    d_sh_r <= d_sh_r;
                    brw_r  <= brw_r;
                    cnt_r  <= cnt_r;
                end
            endcase
        end
    end

    // Handshake and status flags decode straight from the state register,
    // so there is no combinational path from out_ready to in_ready.
    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = (state_r == ST_DONE);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.diff      = d_sh_r;
    assign bus.bout      = brw_r;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Self-checking bench for serial_full_subtractor: directed cases at
// WIDTH=8, an asynchronous reset abort, and randomized operands with
// random consumer stalls at WIDTH 1, 8 and 16 against an arithmetic model.
module tb_serial_full_subtractor;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    serial_full_subtractor_if #(.WIDTH(1))  bus1 ();
    serial_full_subtractor_if #(.WIDTH(8))  bus8 ();
    serial_full_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_full_subtractor #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    serial_full_subtractor #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_full_subtractor #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction; negative result means borrow-out.
    function automatic void ref_sub(input int w, input int unsigned av, input int unsigned bv,
                                    input int unsigned biv, output int unsigned dv, output bit bov);
        int r;
        r   = int'(av) - int'(bv) - int'(biv);
        bov = (r < 0);
        dv  = int'(r) & ((32'd1 << w) - 32'd1);
    endfunction

    // Directed WIDTH=8 operation: checks latency, result, stability under a
    // stall, and optionally pokes in_valid while the block is busy.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic biv,
                          input int stall, input bit poke);
        int unsigned ed;
        bit          eb;
        int          n;
        ref_sub(8, 32'(av), 32'(bv), 32'(biv), ed, eb);
        @(negedge clk);
        check_eq("op8_in_ready", 32'(bus8.in_ready), 32'd1);
        bus8.in_valid = 1'b1;
        bus8.a        = av;
        bus8.b        = bv;
        bus8.bin      = biv;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus8.a        = 8'($urandom);
        bus8.b        = 8'($urandom);
        check_eq("op8_busy", 32'(bus8.busy), 32'd1);
        n = 0;
        while (!bus8.out_valid && n < 40) begin
            if (poke) begin
                bus8.in_valid = 1'b1;
                bus8.a        = 8'($urandom);
                bus8.bin      = 1'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus8.in_valid = 1'b0;
        check_eq("op8_latency", 32'(n), 32'd8);
        check_eq("op8_diff", 32'(bus8.diff), ed);
        check_eq("op8_bout", 32'(bus8.bout), 32'(eb));
        repeat (stall) begin
            bus8.in_valid = poke;
            @(posedge clk);
            #1;
            check_eq("stall_out_valid", 32'(bus8.out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(bus8.in_ready), 32'd0);
            check_eq("stall_diff", 32'(bus8.diff), ed);
            check_eq("stall_bout", 32'(bus8.bout), 32'(eb));
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus8.out_ready = 1'b0;
        check_eq("drain_out_valid", 32'(bus8.out_valid), 32'd0);
        check_eq("drain_in_ready", 32'(bus8.in_ready), 32'd1);
        check_eq("drain_busy", 32'(bus8.busy), 32'd0);
    endtask

    task automatic rnd_w1(input int n);
        logic        ra, rb, rbi;
        int unsigned ed;
        bit          eb, seen, done;
        int          guard;
        for (int i = 0; i < n; i++) begin
            ra = 1'($urandom); rb = 1'($urandom); rbi = 1'($urandom);
            ref_sub(1, 32'(ra), 32'(rb), 32'(rbi), ed, eb);
            @(negedge clk);
            guard = 0;
            while (!bus1.in_ready && guard < 100) begin @(negedge clk); guard++; end
            bus1.in_valid = 1'b1; bus1.a = ra; bus1.b = rb; bus1.bin = rbi;
            @(negedge clk);
            bus1.in_valid = 1'b0; bus1.a = 1'($urandom); bus1.b = 1'($urandom);
            seen = 1'b0; done = 1'b0; guard = 0;
            while (!done && guard < 200) begin
                if (bus1.out_valid && !seen) begin
                    check_eq("w1_diff", 32'(bus1.diff), ed);
                    check_eq("w1_bout", 32'(bus1.bout), 32'(eb));
                    seen = 1'b1;
                end
                bus1.out_ready = ($urandom_range(0, 2) == 0);
                done = bus1.out_valid && bus1.out_ready;
                @(negedge clk);
                guard++;
            end
            bus1.out_ready = 1'b0;
            check_eq("w1_drain", 32'(done), 32'd1);
        end
    endtask

    task automatic rnd_w8(input int n);
        logic [7:0]  ra, rb;
        logic        rbi;
        int unsigned ed;
        bit          eb, seen, done;
        int          guard;
        for (int i = 0; i < n; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            ref_sub(8, 32'(ra), 32'(rb), 32'(rbi), ed, eb);
            @(negedge clk);
            guard = 0;
            while (!bus8.in_ready && guard < 100) begin @(negedge clk); guard++; end
            bus8.in_valid = 1'b1; bus8.a = ra; bus8.b = rb; bus8.bin = rbi;
            @(negedge clk);
            bus8.in_valid = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            seen = 1'b0; done = 1'b0; guard = 0;
            while (!done && guard < 200) begin
                if (bus8.out_valid && !seen) begin
                    check_eq("w8_diff", 32'(bus8.diff), ed);
                    check_eq("w8_bout", 32'(bus8.bout), 32'(eb));
                    seen = 1'b1;
                end
                bus8.out_ready = ($urandom_range(0, 2) == 0);
                done = bus8.out_valid && bus8.out_ready;
                @(negedge clk);
                guard++;
            end
            bus8.out_ready = 1'b0;
            check_eq("w8_drain", 32'(done), 32'd1);
        end
    endtask

    task automatic rnd_w16(input int n);
        logic [15:0] ra, rb;
        logic        rbi;
        int unsigned ed;
        bit          eb, seen, done;
        int          guard;
        for (int i = 0; i < n; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom);
            ref_sub(16, 32'(ra), 32'(rb), 32'(rbi), ed, eb);
            @(negedge clk);
            guard = 0;
            while (!bus16.in_ready && guard < 100) begin @(negedge clk); guard++; end
            bus16.in_valid = 1'b1; bus16.a = ra; bus16.b = rb; bus16.bin = rbi;
            @(negedge clk);
            bus16.in_valid = 1'b0; bus16.a = 16'($urandom); bus16.b = 16'($urandom);
            seen = 1'b0; done = 1'b0; guard = 0;
            while (!done && guard < 200) begin
                if (bus16.out_valid && !seen) begin
                    check_eq("w16_diff", 32'(bus16.diff), ed);
                    check_eq("w16_bout", 32'(bus16.bout), 32'(eb));
                    seen = 1'b1;
                end
                bus16.out_ready = ($urandom_range(0, 2) == 0);
                done = bus16.out_valid && bus16.out_ready;
                @(negedge clk);
                guard++;
            end
            bus16.out_ready = 1'b0;
            check_eq("w16_drain", 32'(done), 32'd1);
        end
    endtask

    // Main sequence.
    initial begin
        bit any_valid;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus1.in_valid  = 1'b0; bus1.a  = 1'b0;  bus1.b  = 1'b0;  bus1.bin  = 1'b0; bus1.out_ready  = 1'b0;
        bus8.in_valid  = 1'b0; bus8.a  = 8'h00; bus8.b  = 8'h00; bus8.bin  = 1'b0; bus8.out_ready  = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = 16'h0; bus16.b = 16'h0; bus16.bin = 1'b0; bus16.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(bus8.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check_eq("rst_diff", 32'(bus8.diff), 32'd0);
        check_eq("rst_bout", 32'(bus8.bout), 32'd0);
        check_eq("rst_busy", 32'(bus8.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        do_op8(8'h05, 8'h03, 1'b0, 0, 1'b0);
        do_op8(8'h03, 8'h05, 1'b0, 0, 1'b0);
        do_op8(8'h00, 8'h00, 1'b1, 0, 1'b0);
        do_op8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        do_op8(8'hFF, 8'h00, 1'b0, 0, 1'b0);
        do_op8(8'h5A, 8'hC3, 1'b1, 5, 1'b1);

        // Reset in SHIFT with cnt=3 aborts the operation.
        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.bin = 1'b0;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_in_ready", 32'(bus8.in_ready), 32'd1);
        check_eq("abort_out_valid", 32'(bus8.out_valid), 32'd0);
        check_eq("abort_diff", 32'(bus8.diff), 32'd0);
        check_eq("abort_bout", 32'(bus8.bout), 32'd0);
        check_eq("abort_busy", 32'(bus8.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        any_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            any_valid = any_valid | bus8.out_valid;
        end
        check_eq("abort_no_result", 32'(any_valid), 32'd0);
        do_op8(8'h10, 8'h01, 1'b0, 0, 1'b0);

        // Randomized operands with consumer stalls, all widths in parallel.
        fork
            rnd_w1(40);
            rnd_w8(60);
            rnd_w16(40);
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
